// File: rtl/wb_stage_pipe.sv
// Write-back stage: X->W pipeline register, W-stage decode, load alignment with stall hold,
// RegFile write port, tohost CSR and retired-instruction counter.
module wb_stage_pipe #(
    parameter int          XLEN        = 32,
    parameter logic [11:0] TOHOST_ADDR = 12'h51E,
    parameter int          INSTRET_W   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_valid,
    input  logic [31:0]          x_inst,
    input  logic [XLEN-1:0]      x_pc,
    input  logic [XLEN-1:0]      x_alu,
    input  logic [XLEN-1:0]      x_csr_wdata,
    input  logic                 stall,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 w_valid,
    output logic [31:0]          w_inst,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [XLEN-1:0]      csr_tohost,
    output logic [INSTRET_W-1:0] instret
);

    localparam int OFFW = $clog2(XLEN / 8);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        WB_MEM = 2'd0,
        WB_ALU = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_csr_wdata;
    logic            hold_flag;
    logic [XLEN-1:0] hold_data;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_load;
    logic            is_tohost;
    logic            reg_wen;
    logic            retire;
    wb_sel_e         wb_sel;
    logic [OFFW-1:0] off;
    logic [7:0]      shamt;
    logic [XLEN-1:0] raw_data;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    assign opcode    = w_inst[6:0];
    assign funct3    = w_inst[14:12];
    assign is_load   = (opcode == OPC_LOAD);
    assign is_tohost = (opcode == OPC_SYSTEM) && (funct3[1:0] == 2'b01)
                       && (w_inst[31:20] == TOHOST_ADDR);
    assign retire    = w_valid && !stall;
    assign rf_waddr  = w_inst[11:7];
    assign rf_we     = w_valid && reg_wen && (rf_waddr != 5'd0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wb_sel  = WB_ALU;
        reg_wen = 1'b0;
        unique case (opcode)
            OPC_LOAD:                            begin wb_sel = WB_MEM; reg_wen = 1'b1; end
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: reg_wen = 1'b1;
            OPC_JAL, OPC_JALR:                   begin wb_sel = WB_PC4; reg_wen = 1'b1; end
            OPC_OP32, OPC_OP_IMM32:              reg_wen = (XLEN == 64);
            default:                             ;
        endcase
    end

    // A stalled load keeps the word it saw on its first W cycle; DMEM may move on afterwards.
    assign raw_data = hold_flag ? hold_data : dmem_rdata;
    assign off      = w_alu[OFFW-1:0];

    always_comb begin
        shamt = 8'd0;
        case (funct3[1:0])
            2'b00:   shamt = 8'({off, 3'b000});
            2'b01:   shamt = 8'({off[OFFW-1:1], 4'b0000});
            2'b10:   shamt = (XLEN == 64) ? 8'({off[OFFW-1], 5'b00000}) : 8'd0;
            default: shamt = 8'd0;
        endcase
    end

    assign shifted = raw_data >> shamt;

    always_comb begin
        load_data = raw_data;
        case (funct3)
            3'b000:  load_data = XLEN'($signed(shifted[7:0]));
            3'b001:  load_data = XLEN'($signed(shifted[15:0]));
            3'b010:  load_data = XLEN'($signed(shifted[31:0]));
            3'b100:  load_data = XLEN'(shifted[7:0]);
            3'b101:  load_data = XLEN'(shifted[15:0]);
            3'b110:  load_data = XLEN'(shifted[31:0]);
            default: load_data = raw_data;
        endcase
    end

    always_comb begin
        rf_wdata = w_alu;
        case (wb_sel)
            WB_MEM:  rf_wdata = load_data;
            WB_PC4:  rf_wdata = w_pc + XLEN'(4);
            default: rf_wdata = w_alu;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid     <= 1'b0;
            w_inst      <= 32'h0000_0013;
            w_pc        <= '0;
            w_alu       <= '0;
            w_csr_wdata <= '0;
            hold_flag   <= 1'b0;
            hold_data   <= '0;
            csr_tohost  <= '0;
            instret     <= '0;
        end else begin
            if (!stall) begin
                w_valid     <= x_valid;
                w_inst      <= x_inst;
                w_pc        <= x_pc;
                w_alu       <= x_alu;
                w_csr_wdata <= x_csr_wdata;
                hold_flag   <= 1'b0;
            end else if (!hold_flag && is_load) begin
                hold_flag <= 1'b1;
                hold_data <= dmem_rdata;
            end
            // Tohost and instret update only on the leaving edge, so a long stall counts once.
            if (retire) begin
                instret <= instret + INSTRET_W'(1);
                if (is_tohost) csr_tohost <= w_csr_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: directed scenarios plus randomized traffic against a
// behavioural model; a second instance with a 4-bit instret exercises counter wrap.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_valid;
    logic [31:0] x_inst, x_pc, x_alu, x_csr_wdata, dmem_rdata;
    logic        stall;

    logic        w_valid, rf_we;
    logic [31:0] w_inst, rf_wdata, csr_tohost;
    logic [4:0]  rf_waddr;
    logic [63:0] instret;

    logic        w_valid4, rf_we4;
    logic [31:0] w_inst4, rf_wdata4, csr_tohost4;
    logic [4:0]  rf_waddr4;
    logic [3:0]  instret4;

    int checks = 0;
    int failures = 0;

    // model of W-stage contents
    logic        m_wv, m_first;
    logic [31:0] m_inst, m_pc, m_alu, m_csr, m_mem, m_tohost;
    logic [63:0] m_instret;
    logic [63:0] base;

    always #5 clk = ~clk;

    wb_stage_pipe dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_inst(x_inst), .x_pc(x_pc), .x_alu(x_alu),
        .x_csr_wdata(x_csr_wdata), .stall(stall), .dmem_rdata(dmem_rdata),
        .w_valid(w_valid), .w_inst(w_inst), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .csr_tohost(csr_tohost), .instret(instret)
    );

    wb_stage_pipe #(.INSTRET_W(4)) dut4 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_inst(x_inst), .x_pc(x_pc), .x_alu(x_alu),
        .x_csr_wdata(x_csr_wdata), .stall(stall), .dmem_rdata(dmem_rdata),
        .w_valid(w_valid4), .w_inst(w_inst4), .rf_we(rf_we4), .rf_waddr(rf_waddr4),
        .rf_wdata(rf_wdata4), .csr_tohost(csr_tohost4), .instret(instret4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_wdata(input logic [31:0] inst, pc, alu, mem);
        logic [31:0] b, h;
        int off;
        off = int'(alu % 4);
        b = (mem >> (8 * off)) & 32'hFF;
        h = (mem >> (16 * (off / 2))) & 32'hFFFF;
        if (inst[6:0] == 7'h03) begin
            case (inst[14:12])
                3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
                3'd4:    return b;
                3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
                3'd5:    return h;
                default: return mem;
            endcase
        end
        if (inst[6:0] == 7'h6F || inst[6:0] == 7'h67) return pc + 32'd4;
        return alu;
    endfunction

    function automatic logic exp_we(input logic v, input logic [31:0] inst);
        logic writes;
        writes = inst[6:0] inside {7'h03, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67};
        return v && writes && (inst[11:7] != 5'd0);
    endfunction

    function automatic logic tohost_write(input logic [31:0] inst);
        return inst[6:0] == 7'h73 && (inst[14:12] == 3'd1 || inst[14:12] == 3'd5)
               && inst[31:20] == 12'h51E;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73, 7'h23, 7'h63};
        logic [2:0]  lf3 [5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0]  sf3 [4]  = '{3'd1, 3'd5, 3'd2, 3'd0};
        logic [31:0] inst;
        inst = $urandom;
        inst[6:0] = ops[$urandom_range(0, 9)];
        if (inst[6:0] == 7'h03) inst[14:12] = lf3[$urandom_range(0, 4)];
        if (inst[6:0] == 7'h73) begin
            inst[14:12] = sf3[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) inst[31:20] = 12'h51E;
        end
        return inst;
    endfunction

    // present inputs for the current cycle and compare every output with the model
    task automatic step(input logic r, input logic v, input logic [31:0] inst, pc, alu, csr,
                        input logic st, input logic [31:0] rd);
        logic [31:0] mem;
        rst = r; x_valid = v; x_inst = inst; x_pc = pc; x_alu = alu; x_csr_wdata = csr;
        stall = st; dmem_rdata = rd;
        #1;
        mem = m_first ? rd : m_mem;
        chk("w_valid", w_valid, m_wv);
        chk("w_inst", w_inst, m_inst);
        chk("rf_we", rf_we, exp_we(m_wv, m_inst));
        chk("rf_waddr", rf_waddr, m_inst[11:7]);
        chk("rf_wdata", rf_wdata, exp_wdata(m_inst, m_pc, m_alu, mem));
        chk("csr_tohost", csr_tohost, m_tohost);
        chk("instret", instret, m_instret);
        chk("instret4", instret4, m_instret[3:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_wv = 1'b0; m_inst = 32'h13; m_pc = '0; m_alu = '0; m_csr = '0;
            m_first = 1'b1; m_mem = '0; m_tohost = '0; m_instret = '0;
        end else begin
            if (m_wv && !stall) begin
                m_instret = m_instret + 64'd1;
                if (tohost_write(m_inst)) m_tohost = m_csr;
            end
            if (stall) begin
                if (m_first) begin
                    m_mem = dmem_rdata;
                    m_first = 1'b0;
                end
            end else begin
                m_wv = x_valid; m_inst = x_inst; m_pc = x_pc; m_alu = x_alu; m_csr = x_csr_wdata;
                m_first = 1'b1;
            end
        end
        #1;
    endtask

    task automatic cyc(input logic r, input logic v, input logic [31:0] inst, pc, alu, csr,
                       input logic st, input logic [31:0] rd);
        step(r, v, inst, pc, alu, csr, st, rd);
        tick();
    endtask

    localparam logic [31:0] LB     = {12'h0, 5'd1, 3'b000, 5'd5, 7'h03};
    localparam logic [31:0] LBU    = {12'h0, 5'd1, 3'b100, 5'd5, 7'h03};
    localparam logic [31:0] LW     = {12'h0, 5'd1, 3'b010, 5'd6, 7'h03};
    localparam logic [31:0] CSRRW  = {12'h51E, 5'd1, 3'b001, 5'd0, 7'h73};
    localparam logic [31:0] ADDI0  = {12'd5, 5'd0, 3'b000, 5'd0, 7'h13};
    localparam logic [31:0] ADDI3  = {12'd5, 5'd0, 3'b000, 5'd3, 7'h13};
    localparam logic [31:0] JAL1   = {20'h0, 5'd1, 7'h6F};

    initial begin
        m_wv = 1'b0; m_first = 1'b1; m_inst = 32'h13; m_pc = '0; m_alu = '0; m_csr = '0;
        m_mem = '0; m_tohost = '0; m_instret = '0;
        rst = 1'b1; x_valid = 1'b0; x_inst = 32'h13; x_pc = '0; x_alu = '0; x_csr_wdata = '0;
        stall = 1'b0; dmem_rdata = '0;
        @(negedge clk);

        // reset held two cycles
        rst = 1'b1; tick(); tick();
        step(1'b0, 1'b1, LB, 32'h0, 32'h3, 32'h0, 1'b0, 32'h0);
        chk("rst_w_valid", w_valid, 1'b0);
        chk("rst_w_inst", w_inst, 32'h13);
        chk("rst_instret", instret, 64'd0);
        chk("rst_tohost", csr_tohost, 32'h0);
        chk("rst_rf_we", rf_we, 1'b0);
        tick();

        // LB then LBU at offset 3
        step(1'b0, 1'b1, LBU, 32'h4, 32'h3, 32'h0, 1'b0, 32'h80FF_1234);
        chk("lb_we", rf_we, 1'b1);
        chk("lb_waddr", rf_waddr, 5'd5);
        chk("lb_data", rf_wdata, 32'hFFFF_FF80);
        tick();
        step(1'b0, 1'b1, LW, 32'h8, 32'h0, 32'h0, 1'b0, 32'h80FF_1234);
        chk("lbu_data", rf_wdata, 32'h0000_0080);
        tick();

        // LW stalled three cycles, DMEM word changes after the first W cycle
        cyc(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b1, 32'hCAFE_BABE);
        cyc(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        chk("lw_hold", rf_wdata, 32'hCAFE_BABE);
        tick();
        step(1'b0, 1'b1, CSRRW, 32'h10, 32'h0, 32'h1, 1'b0, 32'h0);
        chk("lw_release", rf_wdata, 32'hCAFE_BABE);
        tick();

        // CSRRW tohost held by a four-cycle stall
        base = m_instret;
        repeat (4) cyc(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        chk("csr_before_retire", csr_tohost, 32'h0);
        cyc(1'b0, 1'b1, ADDI0, 32'h14, 32'h5, 32'h0, 1'b0, 32'h0);
        chk("csr_tohost", csr_tohost, 32'h1);
        chk("csr_instret_once", instret, base + 64'd1);

        // ADDI x0, JAL x1 at 0x100, bubble
        step(1'b0, 1'b1, JAL1, 32'h100, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("addi_x0_we", rf_we, 1'b0);
        tick();
        step(1'b0, 1'b0, ADDI3, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("jal_we", rf_we, 1'b1);
        chk("jal_data", rf_wdata, 32'h104);
        tick();
        base = m_instret;
        step(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("bubble_we", rf_we, 1'b0);
        tick();
        chk("bubble_instret", instret, base);

        // reset arriving mid-stall drops the pending tohost write
        cyc(1'b0, 1'b1, CSRRW, 32'h20, 32'h0, 32'h7, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        cyc(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rst_stall_tohost", csr_tohost, 32'h0);
        chk("rst_stall_valid", w_valid, 1'b0);
        tick();

        // 17 retires on the 4-bit counter wrap to 1
        cyc(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (17) cyc(1'b0, 1'b1, ADDI3, 32'h0, 32'h1, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("instret4_wrap", instret4, 4'd1);
        chk("instret_17", instret, 64'd17);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'b0, $urandom_range(0, 9) < 8, rand_inst(), $urandom, $urandom, $urandom,
                $urandom_range(0, 9) < 3, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
